// File: rtl/wb_syscall_unit.sv
// Writeback-stage result/address select plus a syscall engine: prints signed
// ints and chars over a valid/ready byte port, halts on exit/break.
`timescale 1ns/1ps
module wb_syscall_unit #(
  parameter int unsigned RA_REG = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWriteW,
  input  logic        MemtoRegW,
  input  logic [31:0] ReadDataW,
  input  logic [31:0] ALUOutW,
  input  logic [4:0]  WriteRegW,
  input  logic [31:0] PCPlus4W,
  input  logic        JalW,
  input  logic        sysW,
  input  logic        breakW,
  input  logic [31:0] regvW,
  input  logic [31:0] regaW,
  output logic        RegWriteOut,
  output logic [4:0]  WriteRegOut,
  output logic [31:0] ResultW,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        stall,
  output logic        halted
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned IDXW = 4;
  localparam int unsigned DIGW = 4;
  localparam int unsigned BW   = 8;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(9);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_EMIT,
    S_DONE,
    S_HALT
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] mag_q, mag_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [DIGW-1:0] digit_q, digit_d;
  logic            started_q, started_d;
  logic            last_q, last_d;
  logic [BW-1:0]   byte_q, byte_d;

  logic            sys_int, sys_char, sys_exit;
  logic [XLEN-1:0] pow_cur;

  // Power of ten consumed at conversion index 0 (10^9) .. 9 (10^0).
  function automatic logic [XLEN-1:0] pow10(input logic [IDXW-1:0] idx);
    case (idx)
      4'd0:    pow10 = 32'd1000000000;
      4'd1:    pow10 = 32'd100000000;
      4'd2:    pow10 = 32'd10000000;
      4'd3:    pow10 = 32'd1000000;
      4'd4:    pow10 = 32'd100000;
      4'd5:    pow10 = 32'd10000;
      4'd6:    pow10 = 32'd1000;
      4'd7:    pow10 = 32'd100;
      4'd8:    pow10 = 32'd10;
      default: pow10 = 32'd1;
    endcase
  endfunction

  assign ResultW     = JalW ? PCPlus4W : (MemtoRegW ? ReadDataW : ALUOutW);
  assign WriteRegOut = JalW ? RW'(RA_REG) : WriteRegW;
  assign RegWriteOut = RegWriteW | JalW;

  assign sys_int  = sysW && (regvW == 32'd1);
  assign sys_char = sysW && (regvW == 32'd11);
  assign sys_exit = sysW && (regvW == 32'd10);
  assign pow_cur  = pow10(idx_q);

  // Freeze upstream the same cycle a live syscall/break shows up in IDLE.
  assign stall = rst_n & (((state_q != S_IDLE) && (state_q != S_DONE)) ||
                          ((state_q == S_IDLE) && (breakW || sys_int || sys_char || sys_exit)));
  assign char_valid = (state_q == S_EMIT);
  assign char_data  = byte_q;
  assign halted     = (state_q == S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mag_q     <= '0;
      idx_q     <= '0;
      digit_q   <= '0;
      started_q <= 1'b0;
      last_q    <= 1'b0;
      byte_q    <= '0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      idx_q     <= idx_d;
      digit_q   <= digit_d;
      started_q <= started_d;
      last_q    <= last_d;
      byte_q    <= byte_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    idx_d     = idx_q;
    digit_d   = digit_q;
    started_d = started_q;
    last_d    = last_q;
    byte_d    = byte_q;
    case (state_q)
      S_IDLE: begin
        if (breakW || sys_exit) begin
          state_d = S_HALT;
        end else if (sys_char) begin
          byte_d  = regaW[7:0];
          last_d  = 1'b1;
          state_d = S_EMIT;
        end else if (sys_int) begin
          idx_d     = '0;
          digit_d   = '0;
          started_d = 1'b0;
          if (regaW[XLEN-1]) begin
            mag_d   = XLEN'(~regaW + 32'd1);
            byte_d  = 8'h2d;
            last_d  = 1'b0;
            state_d = S_EMIT;
          end else begin
            mag_d   = regaW;
            state_d = S_CONV;
          end
        end
      end
      S_CONV: begin
        if (mag_q >= pow_cur) begin
          mag_d   = mag_q - pow_cur;
          digit_d = digit_q + DIGW'(1);
        end else begin
          idx_d   = idx_q + IDXW'(1);
          digit_d = '0;
          // Skip leading zeros; the units digit always prints so 0 gives "0".
          if ((digit_q != '0) || started_q || (idx_q == LAST_IDX)) begin
            byte_d    = 8'h30 + BW'(digit_q);
            started_d = 1'b1;
            last_d    = (idx_q == LAST_IDX);
            state_d   = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (char_ready) begin
          state_d = last_q ? S_DONE : S_CONV;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_syscall_unit.sv
// Scoreboard bench for wb_syscall_unit: expected console bytes are queued by
// the sequencer and popped/compared by an independent monitor.
`timescale 1ns/1ps
module tb_wb_syscall_unit;

  logic        clk, rst_n;
  logic        RegWriteW, MemtoRegW, JalW, sysW, breakW;
  logic [31:0] ReadDataW, ALUOutW, PCPlus4W, regvW, regaW;
  logic [4:0]  WriteRegW;
  logic        RegWriteOut, char_valid, char_ready, stall, halted;
  logic [4:0]  WriteRegOut;
  logic [31:0] ResultW;
  logic [7:0]  char_data;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  exp_q[$];
  bit          rand_ready = 1'b0;

  wb_syscall_unit #(.RA_REG(31)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .ReadDataW(ReadDataW),
    .ALUOutW(ALUOutW), .WriteRegW(WriteRegW), .PCPlus4W(PCPlus4W),
    .JalW(JalW), .sysW(sysW), .breakW(breakW), .regvW(regvW), .regaW(regaW),
    .RegWriteOut(RegWriteOut), .WriteRegOut(WriteRegOut), .ResultW(ResultW),
    .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
    .stall(stall), .halted(halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Console sink: ready either tied high or randomly toggled.
  initial begin
    char_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      char_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops one expected byte per accepted transfer.
  initial begin
    logic       pv, pr;
    logic [7:0] pd, e;
    pv = 1'b0; pr = 1'b0; pd = '0; e = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr && char_valid) check("char_data_stable", 32'(char_data), 32'(pd));
        if (char_valid) check("valid_implies_stall", 32'(stall), 32'd1);
        if (char_valid && char_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_byte: got 0x%0h with none expected", char_data);
          end else begin
            e = exp_q.pop_front();
            check("byte", 32'(char_data), 32'(e));
          end
        end
        pv = char_valid; pr = char_ready; pd = char_data;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // Issue one syscall, hold sysW through DONE, then retire it.
  task automatic syscall(input logic [31:0] v0, input logic [31:0] a0, input string s,
                         input int exp_stall_cycles, input bit rr);
    int  cyc;
    bit  done;
    rand_ready = rr;
    push_str(s);
    step();
    sysW = 1'b1; regvW = v0; regaW = a0;
    #1;
    check("stall_on_issue", 32'(stall), 32'd1);
    cyc = 0; done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      if (stall) cyc++;
      else done = 1'b1;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL stall_timeout: got stall still high expected release");
    end
    check("drained_at_stall_fall", 32'(exp_q.size()), 32'd0);
    check("no_valid_in_done", 32'(char_valid), 32'd0);
    if (exp_stall_cycles >= 0) check("stall_cycles", 32'(cyc), 32'(exp_stall_cycles));
    step();
    sysW = 1'b0;
    rand_ready = 1'b0;
    repeat (4) step();
    check("idle_after_retire", 32'(stall), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; sysW = 1'b0; breakW = 1'b0;
    #1;
    check("rst_char_valid", 32'(char_valid), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    RegWriteW = 1'b0; MemtoRegW = 1'b0; JalW = 1'b0; sysW = 1'b0; breakW = 1'b0;
    ReadDataW = '0; ALUOutW = '0; PCPlus4W = '0; regvW = '0; regaW = '0; WriteRegW = '0;
    #2;
    check("rst_char_data", 32'(char_data), 32'd0);
    do_reset();

    // Writeback path
    JalW = 1'b1; PCPlus4W = 32'h0040_0010; RegWriteW = 1'b0; WriteRegW = 5'd5;
    ALUOutW = 32'h1234_5678; ReadDataW = 32'hdead_beef;
    #1;
    check("jal_regwrite", 32'(RegWriteOut), 32'd1);
    check("jal_waddr", 32'(WriteRegOut), 32'd31);
    check("jal_result", ResultW, 32'h0040_0010);
    JalW = 1'b0; MemtoRegW = 1'b1; RegWriteW = 1'b1;
    #1;
    check("load_result", ResultW, 32'hdead_beef);
    check("load_waddr", 32'(WriteRegOut), 32'd5);
    check("load_regwrite", 32'(RegWriteOut), 32'd1);
    MemtoRegW = 1'b0;
    #1;
    check("alu_result", ResultW, 32'h1234_5678);
    RegWriteW = 1'b0;
    #1;
    check("no_regwrite", 32'(RegWriteOut), 32'd0);

    // Print char: stalled in the issue cycle and the EMIT cycle, then DONE
    syscall(32'd11, 32'h41, "A", 2, 1'b0);
    // Print int under random backpressure and edge values
    syscall(32'd1, 32'h8000_0000, "-2147483648", -1, 1'b1);
    syscall(32'd1, 32'd0, "0", -1, 1'b0);
    syscall(32'd1, 32'd1000, "1000", -1, 1'b1);
    syscall(32'd1, 32'hffff_fff9, "-7", -1, 1'b0);
    syscall(32'd1, 32'd2147483647, "2147483647", -1, 1'b1);
    // Unknown code: no stall, no bytes
    step();
    sysW = 1'b1; regvW = 32'd4; regaW = 32'h55;
    #1;
    check("unknown_no_stall", 32'(stall), 32'd0);
    step();
    sysW = 1'b0;

    // Break together with syscall: halt, no bytes, sticky
    step();
    sysW = 1'b1; breakW = 1'b1; regvW = 32'd11; regaW = 32'h42;
    #1;
    check("break_stall", 32'(stall), 32'd1);
    step();
    sysW = 1'b0; breakW = 1'b0;
    repeat (3) step();
    check("break_halted", 32'(halted), 32'd1);
    check("break_stall_sticky", 32'(stall), 32'd1);
    check("break_no_valid", 32'(char_valid), 32'd0);
    do_reset();

    // Exit syscall
    step();
    sysW = 1'b1; regvW = 32'd10; regaW = '0;
    step();
    sysW = 1'b0;
    repeat (3) step();
    check("exit_halted", 32'(halted), 32'd1);
    check("exit_stall", 32'(stall), 32'd1);
    do_reset();

    // Reset in the middle of printing 123456
    push_str("123456");
    rand_ready = 1'b0;
    step();
    sysW = 1'b1; regvW = 32'd1; regaW = 32'd123456;
    for (int c = 0; c < 500 && exp_q.size() > 4; c++) @(negedge clk);
    check("midprint_progress", 32'(exp_q.size() <= 4), 32'd1);
    @(negedge clk);
    #2;
    do_reset();
    check("after_rst_halted", 32'(halted), 32'd0);
    syscall(32'd11, 32'h5a, "Z", 2, 1'b0);

    check("queue_empty_end", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
